// File: rtl/axi_lite_multi_adder_if.sv
// AXI4-Lite bus bundle for the multi-channel adder slave.
// The slave modport is the adder's view of the bus; the master modport is the
// initiator's view. Clock and reset travel as plain ports beside this bundle.
interface axi_lite_multi_adder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 2
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [RESP_WIDTH-1:0]   bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [RESP_WIDTH-1:0]   rresp;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_multi_adder.sv
// AXI4-Lite slave with NUM_CH independent adder channels (OPA, OPB, RESULT,
// STATUS at 16*c), a CTRL clear register at 0x80 and SLVERR on bad addresses.
// Optional macro ADDER_IRQ_EN adds IRQ_STAT (0x84, W1C) and the adder_irq port.
module axi_lite_multi_adder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_CH     = 4,
  parameter int RESP_WIDTH = 2
) (
  input  logic                  s1_axi_aclk,
  input  logic                  s1_axi_areset,
  axi_lite_multi_adder_if.slave s1_axi
`ifdef ADDER_IRQ_EN
  ,
  output logic                  adder_irq
`endif
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [3:0] NUM_CH_W = 4'(NUM_CH);
  localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = '0;
  localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);

  typedef enum logic [2:0] {K_OPA, K_OPB, K_RESULT, K_STATUS, K_CTRL, K_IRQ, K_BAD} addr_kind_e;

  // Classify an address; bits [1:0] are don't-care, anything above 0xFF is unmapped.
  function automatic addr_kind_e decode_kind(input logic [ADDR_WIDTH-1:0] a);
    addr_kind_e k;
    k = K_BAD;
    if ((a >> 8) == '0) begin
      if (!a[7]) begin
        if ({1'b0, a[6:4]} < NUM_CH_W) begin
          case (a[3:2])
            2'd0:    k = K_OPA;
            2'd1:    k = K_OPB;
            2'd2:    k = K_RESULT;
            default: k = K_STATUS;
          endcase
        end
      end else if (a[6:2] == 5'd0) begin
        k = K_CTRL;
      end
`ifdef ADDER_IRQ_EN
      else if (a[6:2] == 5'd1) begin
        k = K_IRQ;
      end
`endif
    end
    return k;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(input logic [DATA_WIDTH-1:0] old_v,
                                                       input logic [DATA_WIDTH-1:0] new_v,
                                                       input logic [STRB_WIDTH-1:0] strb);
    logic [DATA_WIDTH-1:0] m;
    m = old_v;
    for (int b = 0; b < STRB_WIDTH; b++) begin
      if (strb[b]) m[8*b +: 8] = new_v[8*b +: 8];
    end
    return m;
  endfunction

  // Write-side holding registers
  logic                    aw_held_reg, w_held_reg, bvalid_reg;
  logic [ADDR_WIDTH-1:0]   aw_addr_reg;
  logic [DATA_WIDTH-1:0]   w_data_reg;
  logic [STRB_WIDTH-1:0]   w_strb_reg;
  logic [RESP_WIDTH-1:0]   bresp_reg;
  logic                    awready_int, wready_int, arready_int;
  logic                    wr_commit, wr_ok, wr_ctrl_clear;
  addr_kind_e              wr_kind;
  logic [2:0]              wr_ch;

  // Channel state
  logic [DATA_WIDTH-1:0]   opa_reg    [NUM_CH];
  logic [DATA_WIDTH-1:0]   opb_reg    [NUM_CH];
  logic [DATA_WIDTH-1:0]   result_reg [NUM_CH];
  logic                    carry_reg  [NUM_CH];
  logic                    valid_reg  [NUM_CH];
  logic                    pend_a_reg [NUM_CH];
  logic                    pend_b_reg [NUM_CH];
  logic [NUM_CH-1:0]       fire_vec;

  // Read side
  logic                    rvalid_reg;
  logic [DATA_WIDTH-1:0]   rdata_reg, rd_data_next;
  logic [RESP_WIDTH-1:0]   rresp_reg, rd_resp_next;
  addr_kind_e              rd_kind;
  logic [2:0]              rd_ch;

  // A ready stays low from its own handshake until the response has drained.
  assign awready_int = ~aw_held_reg & ~bvalid_reg;
  assign wready_int  = ~w_held_reg & ~bvalid_reg;
  assign arready_int = ~rvalid_reg;

  assign s1_axi.awready = awready_int;
  assign s1_axi.wready  = wready_int;
  assign s1_axi.bvalid  = bvalid_reg;
  assign s1_axi.bresp   = bresp_reg;
  assign s1_axi.arready = arready_int;
  assign s1_axi.rvalid  = rvalid_reg;
  assign s1_axi.rdata   = rdata_reg;
  assign s1_axi.rresp   = rresp_reg;

  assign wr_commit     = aw_held_reg & w_held_reg & ~bvalid_reg;
  assign wr_kind       = decode_kind(aw_addr_reg);
  assign wr_ch         = aw_addr_reg[6:4];
  assign wr_ok         = (wr_kind == K_OPA) || (wr_kind == K_OPB) ||
                         (wr_kind == K_CTRL) || (wr_kind == K_IRQ);
  assign wr_ctrl_clear = wr_commit && (wr_kind == K_CTRL) && w_strb_reg[0] && w_data_reg[0];

  // Capture AW and W independently, commit once both are held, then hold B until bready.
  always_ff @(posedge s1_axi_aclk) begin
    if (s1_axi_areset) begin
      aw_held_reg <= 1'b0;
      w_held_reg  <= 1'b0;
      aw_addr_reg <= '0;
      w_data_reg  <= '0;
      w_strb_reg  <= '0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= RESP_OKAY;
    end else begin
      if (s1_axi.awvalid && awready_int) begin
        aw_held_reg <= 1'b1;
        aw_addr_reg <= s1_axi.awaddr;
      end
      if (s1_axi.wvalid && wready_int) begin
        w_held_reg <= 1'b1;
        w_data_reg <= s1_axi.wdata;
        w_strb_reg <= s1_axi.wstrb;
      end
      if (wr_commit) begin
        aw_held_reg <= 1'b0;
        w_held_reg  <= 1'b0;
        bvalid_reg  <= 1'b1;
        bresp_reg   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid_reg && s1_axi.bready) begin
        bvalid_reg <= 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic              wr_opa, wr_opb;
    logic [DATA_WIDTH:0] sum;

    assign wr_opa       = wr_commit && (wr_ch == 3'(gi)) && (wr_kind == K_OPA);
    assign wr_opb       = wr_commit && (wr_ch == 3'(gi)) && (wr_kind == K_OPB);
    assign sum          = {1'b0, opa_reg[gi]} + {1'b0, opb_reg[gi]};
    assign fire_vec[gi] = pend_a_reg[gi] & pend_b_reg[gi];

    // Operand capture and add; a write landing in the compute cycle re-arms its PEND bit.
    always_ff @(posedge s1_axi_aclk) begin
      if (s1_axi_areset || wr_ctrl_clear) begin
        opa_reg[gi]    <= '0;
        opb_reg[gi]    <= '0;
        result_reg[gi] <= '0;
        carry_reg[gi]  <= 1'b0;
        valid_reg[gi]  <= 1'b0;
        pend_a_reg[gi] <= 1'b0;
        pend_b_reg[gi] <= 1'b0;
      end else begin
        if (fire_vec[gi]) begin
          result_reg[gi] <= sum[DATA_WIDTH-1:0];
          carry_reg[gi]  <= sum[DATA_WIDTH];
          valid_reg[gi]  <= 1'b1;
          pend_a_reg[gi] <= 1'b0;
          pend_b_reg[gi] <= 1'b0;
        end
        if (wr_opa) begin
          opa_reg[gi]    <= merge_bytes(opa_reg[gi], w_data_reg, w_strb_reg);
          pend_a_reg[gi] <= 1'b1;
          if (!fire_vec[gi]) valid_reg[gi] <= 1'b0;
        end
        if (wr_opb) begin
          opb_reg[gi]    <= merge_bytes(opb_reg[gi], w_data_reg, w_strb_reg);
          pend_b_reg[gi] <= 1'b1;
          if (!fire_vec[gi]) valid_reg[gi] <= 1'b0;
        end
      end
    end
  end

`ifdef ADDER_IRQ_EN
  logic [NUM_CH-1:0] irq_stat_reg, irq_stat_next;
  logic              adder_irq_reg;
  logic              wr_irq_clr;

  assign wr_irq_clr = wr_commit && (wr_kind == K_IRQ) && w_strb_reg[0];
  assign adder_irq  = adder_irq_reg;

  // W1C clear first, then new completions, so a same-cycle set wins; CTRL clear dominates.
  always_comb begin
    irq_stat_next = irq_stat_reg;
    if (wr_irq_clr) irq_stat_next = irq_stat_next & ~w_data_reg[NUM_CH-1:0];
    irq_stat_next = irq_stat_next | fire_vec;
    if (wr_ctrl_clear) irq_stat_next = '0;
  end

  // Interrupt status and the registered OR that drives the pin.
  always_ff @(posedge s1_axi_aclk) begin
    if (s1_axi_areset) begin
      irq_stat_reg  <= '0;
      adder_irq_reg <= 1'b0;
    end else begin
      irq_stat_reg  <= irq_stat_next;
      adder_irq_reg <= |irq_stat_next;
    end
  end
`endif

  assign rd_kind = decode_kind(s1_axi.araddr);
  assign rd_ch   = s1_axi.araddr[6:4];

  // Read mux over the current register contents.
  always_comb begin
    rd_data_next = '0;
    rd_resp_next = RESP_OKAY;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_ch == 3'(c)) begin
        case (rd_kind)
          K_OPA:    rd_data_next = opa_reg[c];
          K_OPB:    rd_data_next = opb_reg[c];
          K_RESULT: rd_data_next = result_reg[c];
          K_STATUS: rd_data_next = DATA_WIDTH'({pend_b_reg[c], pend_a_reg[c], carry_reg[c], valid_reg[c]});
          default:  ;
        endcase
      end
    end
`ifdef ADDER_IRQ_EN
    if (rd_kind == K_IRQ) rd_data_next = DATA_WIDTH'(irq_stat_reg);
`endif
    if (rd_kind == K_CTRL || rd_kind == K_BAD) begin
      rd_data_next = '0;
      rd_resp_next = RESP_SLVERR;
    end
  end

  // AR handshake samples the mux; R is held stable until rready.
  always_ff @(posedge s1_axi_aclk) begin
    if (s1_axi_areset) begin
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
      rresp_reg  <= RESP_OKAY;
    end else if (s1_axi.arvalid && arready_int) begin
      rvalid_reg <= 1'b1;
      rdata_reg  <= rd_data_next;
      rresp_reg  <= rd_resp_next;
    end else if (rvalid_reg && s1_axi.rready) begin
      rvalid_reg <= 1'b0;
    end
  end
endmodule
